led_scan_driver: RTL and testbench

LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

---
 rtl/led_scan_driver_pkg.sv | 27 ++
 rtl/led_scan_driver_if.sv | 28 ++
 rtl/led_scan_driver_scan_prescaler.sv | 34 +++
 rtl/led_scan_driver.sv | 155 +++++++++++++++
 tb/tb_led_scan_driver.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/led_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// led_scan_pkg
// Shared constants and types for the multiplexed 4-digit LED scan driver.
//   CHAR_BLANK / CHAR_DASH / CHAR_F : character codes fed to the 7-seg decoder
//   scan_state_t                    : display mode (IDLE blank, SHOW message,
//                                     ERR error banner)
//   anode_for()                     : active-low one-cold digit enable
// ---------------------------------------------------------------------------
package led_scan_pkg;

    localparam logic [3:0]  CHAR_BLANK = 4'hF;
    localparam logic [3:0]  CHAR_DASH  = 4'hB;
    localparam logic [3:0]  CHAR_F     = 4'hC;
    localparam logic [15:0] MSG_BLANK  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        ERR  = 2'd2
    } scan_state_t;

    // Active-low enable for one digit: only the selected bit is driven low.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/led_scan_driver_if.sv
// ---------------------------------------------------------------------------
// led_scan_driver_if
// Message/error request side and display side of the LED scan driver.
//   load, msg, error   : requester -> driver
//   load_ack           : driver -> requester, one-cycle apply pulse
//   char, anode        : driver -> display (decoder input, active-low enables)
// Modports: master = requester/display owner, slave = the driver.
// ---------------------------------------------------------------------------
interface led_scan_driver_if;

    logic        load;
    logic [15:0] msg;
    logic        error;
    logic        load_ack;
    logic [3:0]  char;
    logic [3:0]  anode;

    modport master (
        output load, msg, error,
        input  load_ack, char, anode
    );

    modport slave (
        input  load, msg, error,
        output load_ack, char, anode
    );

endinterface

// File: rtl/led_scan_driver_scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Free-running divider that marks the last cycle of each digit slot.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   tick  : high while the counter sits at SCAN_DIV-1 (one cycle per slot)
// SCAN_DIV legal range 2..65535.
// ---------------------------------------------------------------------------
module scan_prescaler #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    logic [15:0] count_r;

    assign tick = (count_r == LAST);

    // Slot counter: 0..SCAN_DIV-1, wrapping on tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (tick) begin
            count_r <= 16'd0;
        end else begin
            count_r <= count_r + 16'd1;
        end
    end

endmodule

// File: rtl/led_scan_driver.sv
// ---------------------------------------------------------------------------
// led_scan_driver
// Scans a 4-digit multiplexed LED display. A loaded message is held in a
// shadow register and only becomes visible at a frame boundary (tick while
// digit 3 is selected), so one frame never mixes two messages. An error
// pulse forces an error banner (C,B,B,B) at the next boundary; a pending
// message then applies at the boundary after that.
//   clk        : rising-edge clock
//   reset      : synchronous, active-high
//   bus        : led_scan_driver_if.slave (load/msg/error in,
//                load_ack/char/anode out, all outputs registered)
// Optional build macro: LED_SCAN_BLINK_EN -- the error banner blinks
// (blank on every other frame).
// ---------------------------------------------------------------------------
module led_scan_driver
    import led_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    led_scan_driver_if.slave   bus
);

    logic        tick_s;
    logic        boundary_s;
    logic        err_now_s;
    logic        apply_s;
    logic [3:0]  char_s;
    scan_state_t state_r;
    scan_state_t state_s;
    logic [1:0]  index_r;
    logic        pending_r;
    logic        err_pend_r;
    logic [15:0] disp_r;
    logic [15:0] shadow_r;
    logic        ack_r;
    logic [3:0]  char_r;
    logic [3:0]  anode_r;
`ifdef LED_SCAN_BLINK_EN
    logic        toggle_r;
`endif

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign boundary_s   = tick_s & (index_r == 2'd3);
    assign bus.load_ack = ack_r;
    assign bus.char     = char_r;
    assign bus.anode    = anode_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decision at frame boundaries; error beats a message apply,
    // and a load arriving in the boundary cycle counts as already pending.
    always_comb begin
        state_s   = state_r;
        apply_s   = 1'b0;
        err_now_s = err_pend_r | bus.error;
        if (boundary_s) begin
            if (err_now_s) begin
                state_s = ERR;
            end else if (pending_r | bus.load) begin
                state_s = SHOW;
                apply_s = 1'b1;
            end else begin
                state_s = state_r;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Character for the digit currently being latched, from the old state so
    // the whole frame is rendered from one message/mode.
    always_comb begin
        char_s = CHAR_BLANK;
        case (state_r)
            IDLE: char_s = CHAR_BLANK;
            SHOW: char_s = disp_r[{index_r, 2'b00} +: 4];
            ERR: begin
                if (index_r == 2'd3) begin
                    char_s = CHAR_F;
                end else begin
                    char_s = CHAR_DASH;
                end
`ifdef LED_SCAN_BLINK_EN
                if (toggle_r) begin
                    char_s = CHAR_BLANK;
                end else begin
                    char_s = char_s;
                end
`endif
            end
            default: char_s = CHAR_BLANK;
        endcase
    end

    // Digit scan, message shadowing/apply, error latch and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_r    <= 2'd0;
            pending_r  <= 1'b0;
            err_pend_r <= 1'b0;
            disp_r     <= MSG_BLANK;
            shadow_r   <= MSG_BLANK;
            ack_r      <= 1'b0;
            char_r     <= CHAR_BLANK;
            anode_r    <= 4'b1111;
        end else begin
            ack_r <= apply_s;
            if (tick_s) begin
                index_r <= index_r + 2'd1;
                char_r  <= char_s;
                anode_r <= anode_for(index_r);
            end
            if (apply_s) begin
                disp_r    <= bus.load ? bus.msg : shadow_r;
                pending_r <= 1'b0;
            end else if (bus.load) begin
                shadow_r  <= bus.msg;
                pending_r <= 1'b1;
            end
            if (boundary_s) begin
                err_pend_r <= 1'b0;
            end else if (bus.error) begin
                err_pend_r <= 1'b1;
            end
        end
    end

`ifdef LED_SCAN_BLINK_EN
    // Frame parity inside ERR: cleared on entry, flipped every ERR frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_r <= 1'b0;
        end else if (boundary_s && (state_s == ERR) && (state_r != ERR)) begin
            toggle_r <= 1'b0;
        end else if (boundary_s && (state_r == ERR)) begin
            toggle_r <= ~toggle_r;
        end
    end
`endif

endmodule

// File: tb/tb_led_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_led_scan_driver
// Directed scenarios followed by random load/error/reset traffic, every cycle
// compared against a frame-level behavioural model of the display.
// Honors LED_SCAN_BLINK_EN in the model the same way the build does.
// ---------------------------------------------------------------------------
module tb_led_scan_driver;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    led_scan_driver_if bus_if();

    led_scan_driver #(.SCAN_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ack_seen = 0;

    // Model: cycle count since reset, mode (0 blank, 1 message, 2 error),
    // shown message, pending message, pending error, blink parity.
    int          m_k;
    int          m_mode;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    bit          m_pend;
    bit          m_errp;
    bit          m_odd;
    logic [3:0]  e_char;
    logic [3:0]  e_anode;
    bit          e_ack;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_char(input int dig);
        logic [3:0] c;
        if (m_mode == 0) begin
            c = 4'hF;
        end else if (m_mode == 1) begin
            c = 4'((m_disp >> (4 * dig)) & 16'h000F);
        end else begin
            c = (dig == 3) ? 4'hC : 4'hB;
`ifdef LED_SCAN_BLINK_EN
            if (m_odd) c = 4'hF;
`endif
        end
        return c;
    endfunction

    task automatic model_step(input bit r, input bit l, input logic [15:0] m, input bit e);
        int  dig;
        bit  tick;
        bit  bnd;
        if (r) begin
            m_k = 0; m_mode = 0; m_disp = 16'hFFFF; m_shadow = 16'hFFFF;
            m_pend = 0; m_errp = 0; m_odd = 0;
            e_char = 4'hF; e_anode = 4'hF; e_ack = 0;
            return;
        end
        tick  = (m_k % DIV) == DIV - 1;
        dig   = (m_k / DIV) % 4;
        bnd   = tick && (dig == 3);
        e_ack = 0;
        if (tick) begin
            e_char  = model_char(dig);
            e_anode = 4'hF & ~(4'h1 << dig);
        end
        if (bnd) begin
            if (m_mode == 2) m_odd = !m_odd;
            if (m_errp || e) begin
                if (m_mode != 2) m_odd = 0;
                m_mode = 2;
                m_errp = 0;
                if (l) begin m_shadow = m; m_pend = 1; end
            end else if (m_pend || l) begin
                m_disp = l ? m : m_shadow;
                m_pend = 0;
                m_mode = 1;
                e_ack  = 1;
            end
        end else begin
            if (l) begin m_shadow = m; m_pend = 1; end
            if (e) m_errp = 1;
        end
        m_k++;
    endtask

    task automatic step(input bit r, input bit l, input logic [15:0] m, input bit e);
        reset         = r;
        bus_if.load   = l;
        bus_if.msg    = m;
        bus_if.error  = e;
        @(posedge clk);
        model_step(r, l, m, e);
        @(negedge clk);
        check_val("char",  {12'h000, bus_if.char},  {12'h000, e_char});
        check_val("anode", {12'h000, bus_if.anode}, {12'h000, e_anode});
        check_val("load_ack", {15'h0000, bus_if.load_ack}, {15'h0000, e_ack});
        if (bus_if.load_ack) ack_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    // Advance until the next step lands at the given position in a frame.
    task automatic go_to(input int phase);
        for (int i = 0; i < 4 * DIV; i++) begin
            if ((m_k % (4 * DIV)) == phase) break;
            step(1'b0, 1'b0, 16'h0000, 1'b0);
        end
    endtask

    initial begin
        int acks_before;
        reset = 1'b1;
        bus_if.load = 1'b0;
        bus_if.msg = 16'h0000;
        bus_if.error = 1'b0;

        // Reset with a load present (must be discarded), then idle scan.
        step(1'b1, 1'b1, 16'h4321, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        idle(40);
        check_val("idle_no_ack", 16'(ack_seen), 16'd0);

        // Mid-frame load of 1234.
        go_to(6);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(36);

        // Two loads in one frame: only the last is applied, one ack.
        go_to(2);
        acks_before = ack_seen;
        step(1'b0, 1'b1, 16'h1111, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 16'h5678, 1'b0);
        idle(24);
        check_val("double_load_acks", 16'(ack_seen - acks_before), 16'd1);

        // Error coinciding with the apply of 9999, then apply a frame later.
        go_to(5);
        step(1'b0, 1'b1, 16'h9999, 1'b0);
        go_to(15);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(40);

        // Lone error: banner held (steady or blinking) for several frames.
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(80);

        // Boundary-cycle load while in ERR applies directly.
        go_to(15);
        step(1'b0, 1'b1, 16'hA5C3, 1'b0);
        idle(20);

        // Reset mid-frame with a message pending.
        go_to(7);
        step(1'b0, 1'b1, 16'hABCD, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        idle(40);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0),
                 16'($urandom), ($urandom_range(0, 39) == 0));
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
